lc4_regfile_sb: RTL and testbench
=================================

LC4_REGFILE_SB -- requirements
Module: lc4_regfile_sb

Interface
REQ-001 Parameter n, default 16, data width in bits.
REQ-002 Parameter NREG, default 8, register count; power of two, 2..32; AW = log2(NREG).
REQ-003 Parameter WAYS, default 2, number of pipes; 1..4; way index 0 is oldest in program order.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 gwe  in  1  global write enable; gates every state update.
REQ-007 i_rs, i_rt  in  WAYS*AW  per-way source selectors; way w occupies bits [w*AW +: AW].
REQ-008 o_rs_data, o_rt_data  out  WAYS*n  per-way source contents, same packing.
REQ-009 o_rs_busy, o_rt_busy  out  WAYS  per-way scoreboard busy flag of the selected source.
REQ-010 i_rd  in  WAYS*AW  per-way writeback destination.
REQ-011 i_wdata  in  WAYS*n  per-way writeback data.
REQ-012 i_rd_we  in  WAYS  per-way writeback enable.
REQ-013 i_alloc_rd  in  WAYS*AW  per-way destination being issued, for scoreboard marking.
REQ-014 i_alloc_we  in  WAYS  per-way issue-marks-busy enable.

Function
REQ-015 Registers and busy bits SHALL update only on a rising clk edge with gwe=1; with gwe=0 all state holds.
REQ-016 Multiple ways writing one register in one cycle: the highest-indexed enabled way SHALL win.
REQ-017 Reads SHALL be combinational with 0-cycle latency from selector to data.
REQ-018 Read bypass, when enabled (REQ-027): a source matching an enabled i_rd SHALL return that i_wdata, using the highest matching way; otherwise the stored value.
REQ-019 Bypass SHALL not depend on gwe.
REQ-020 Busy bit of register r SHALL be set at the edge when any i_alloc_we[w]=1 with i_alloc_rd[w]=r.
REQ-021 Busy bit of register r SHALL be cleared at the edge when any i_rd_we[w]=1 with i_rd[w]=r and no alloc targets r.
REQ-022 Alloc and writeback to the same register in the same cycle: the busy bit SHALL end set (alloc wins).
REQ-023 o_*_busy SHALL reflect the stored busy bit, forced to 0 in the same cycle when an enabled writeback targets that source and no same-cycle alloc does; same-cycle alloc SHALL NOT affect o_*_busy.
REQ-024 Every register, including index 0, SHALL be general-purpose; there is no hardwired zero.

Reset
REQ-025 rst=1 at an edge SHALL clear all registers and busy bits to 0, regardless of gwe, and SHALL override writeback and alloc in the same cycle.
REQ-026 During rst=1, outputs SHALL still follow REQ-017/018/023 combinationally; one cycle after reset, all reads SHALL return 0 and all busy flags 0.

Configuration
REQ-027 Macro LC4_REGFILE_BYPASS_EN defined: REQ-018 write-to-read data bypass and the REQ-023 busy force-clear SHALL be present.
REQ-028 Macro LC4_REGFILE_BYPASS_EN undefined: reads SHALL return stored values only, so a written value is visible the cycle after the write; o_*_busy SHALL equal the stored bit.

Structure
REQ-029 A shared package SHALL hold the default n, NREG and WAYS constants, and the AW derivation function.
REQ-030 One sub-module, lc4_rf_bypass_sel, SHALL implement the per-port priority match and select (selector, WAYS rd/we/wdata -> hit, data); it is instantiated 2*WAYS times.
REQ-031 The storage array and scoreboard SHALL reside in the top module.

Verification
REQ-032 Reset, then read all 8 registers on every port -> all data 0x0000 and all busy 0.
REQ-033 Way0 and way1 both write r3 (0x1111 and 0x2222), gwe=1 -> bypass read of r3 = 0x2222 that cycle; stored r3 = 0x2222 next cycle (without the macro: stored value that cycle, 0x2222 next).
REQ-034 Write r5=0xBEEF with gwe=0 -> bypass shows 0xBEEF; next cycle r5 still reads 0x0000.
REQ-035 Alloc r2 on way1 -> next cycle o_rs_busy for r2 = 1; writeback r2 -> busy reads 0 that cycle (with macro) and stored bit clear next cycle.
REQ-036 Alloc r4 on way0 and write back r4 on way1 in the same cycle -> busy for r4 = 1 the next cycle.
REQ-037 rst=1 together with a write of r7=0xFFFF and an alloc of r7 -> next cycle r7 = 0x0000 and busy = 0.

Source files
------------

// File: rtl/lc4_regfile_sb_pkg.sv
// Shared constants and helpers for the LC4 superscalar register file with scoreboard.
// Optional write-to-read bypass is enabled by defining LC4_REGFILE_BYPASS_EN.
package lc4_regfile_sb_pkg;

    localparam int unsigned DEFAULT_N    = 16;
    localparam int unsigned DEFAULT_NREG = 8;
    localparam int unsigned DEFAULT_WAYS = 2;

    // Selector width for a register count; NREG is a power of two in 2..32.
    function automatic int unsigned calc_aw(input int unsigned nreg);
        return (nreg < 2) ? 1 : $clog2(nreg);
    endfunction

endpackage

// File: rtl/lc4_regfile_sb_if.sv
// Bundle of per-way read, writeback and scoreboard-allocate signals for lc4_regfile_sb.
// Bypass behaviour is selected by LC4_REGFILE_BYPASS_EN inside the register file.
interface lc4_regfile_sb_if
    import lc4_regfile_sb_pkg::*;
#(
    parameter int unsigned n    = DEFAULT_N,
    parameter int unsigned NREG = DEFAULT_NREG,
    parameter int unsigned WAYS = DEFAULT_WAYS
);

    localparam int unsigned AW = calc_aw(NREG);

    logic                 gwe;
    logic [WAYS*AW-1:0]   i_rs;
    logic [WAYS*AW-1:0]   i_rt;
    logic [WAYS*n-1:0]    o_rs_data;
    logic [WAYS*n-1:0]    o_rt_data;
    logic [WAYS-1:0]      o_rs_busy;
    logic [WAYS-1:0]      o_rt_busy;
    logic [WAYS*AW-1:0]   i_rd;
    logic [WAYS*n-1:0]    i_wdata;
    logic [WAYS-1:0]      i_rd_we;
    logic [WAYS*AW-1:0]   i_alloc_rd;
    logic [WAYS-1:0]      i_alloc_we;

    modport master (
        output gwe, i_rs, i_rt, i_rd, i_wdata, i_rd_we, i_alloc_rd, i_alloc_we,
        input  o_rs_data, o_rt_data, o_rs_busy, o_rt_busy
    );

    modport slave (
        input  gwe, i_rs, i_rt, i_rd, i_wdata, i_rd_we, i_alloc_rd, i_alloc_we,
        output o_rs_data, o_rt_data, o_rs_busy, o_rt_busy
    );

endinterface

// File: rtl/lc4_rf_bypass_sel.sv
// Per-read-port writeback match: returns the data of the highest-indexed enabled way
// whose destination equals the selector.
module lc4_rf_bypass_sel
    import lc4_regfile_sb_pkg::*;
#(
    parameter int unsigned n    = DEFAULT_N,
    parameter int unsigned NREG = DEFAULT_NREG,
    parameter int unsigned WAYS = DEFAULT_WAYS,
    localparam int unsigned AW  = calc_aw(NREG)
) (
    input  logic [AW-1:0]      sel,
    input  logic [WAYS*AW-1:0] rd,
    input  logic [WAYS-1:0]    we,
    input  logic [WAYS*n-1:0]  wdata,
    output logic               hit,
    output logic [n-1:0]       data
);

    // Ascending scan so the youngest (highest) matching way overwrites older ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (we[w] && (rd[w*AW +: AW] == sel)) begin
                hit  = 1'b1;
                data = wdata[w*n +: n];
            end
        end
    end

endmodule

// File: rtl/lc4_regfile_sb.sv
// Multi-way LC4 register file with a per-register busy scoreboard.
// Define LC4_REGFILE_BYPASS_EN for same-cycle writeback-to-read bypass and busy force-clear.
module lc4_regfile_sb
    import lc4_regfile_sb_pkg::*;
#(
    parameter int unsigned n    = DEFAULT_N,
    parameter int unsigned NREG = DEFAULT_NREG,
    parameter int unsigned WAYS = DEFAULT_WAYS
) (
    input  logic          clk,
    input  logic          rst,
    lc4_regfile_sb_if.slave rf
);

    localparam int unsigned AW = calc_aw(NREG);

    logic [n-1:0]    regs_q [NREG];
    logic [n-1:0]    regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] wb_vec;
    logic [NREG-1:0] alloc_vec;

    logic [n-1:0]    rs_data [WAYS];
    logic [n-1:0]    rt_data [WAYS];
    logic [WAYS-1:0] rs_busy;
    logic [WAYS-1:0] rt_busy;

    // Later ways overwrite earlier ones, giving the highest-indexed writer priority.
    always_comb begin
        regs_d    = regs_q;
        wb_vec    = '0;
        alloc_vec = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (rf.i_rd_we[w]) begin
                regs_d[rf.i_rd[w*AW +: AW]] = rf.i_wdata[w*n +: n];
                wb_vec[rf.i_rd[w*AW +: AW]] = 1'b1;
            end
            if (rf.i_alloc_we[w]) begin
                alloc_vec[rf.i_alloc_rd[w*AW +: AW]] = 1'b1;
            end
        end
        // Allocation wins over a same-cycle writeback to the same register.
        busy_d = alloc_vec | (busy_q & ~wb_vec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(NREG); r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else if (rf.gwe) begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar w = 0; w < int'(WAYS); w++) begin : g_read
        logic [AW-1:0] rs_sel;
        logic [AW-1:0] rt_sel;

        assign rs_sel = rf.i_rs[w*AW +: AW];
        assign rt_sel = rf.i_rt[w*AW +: AW];

`ifdef LC4_REGFILE_BYPASS_EN
        logic         rs_hit;
        logic         rt_hit;
        logic [n-1:0] rs_byp;
        logic [n-1:0] rt_byp;

        lc4_rf_bypass_sel #(
            .n    (n),
            .NREG (NREG),
            .WAYS (WAYS)
        ) u_rs_sel (
            .sel   (rs_sel),
            .rd    (rf.i_rd),
            .we    (rf.i_rd_we),
            .wdata (rf.i_wdata),
            .hit   (rs_hit),
            .data  (rs_byp)
        );

        lc4_rf_bypass_sel #(
            .n    (n),
            .NREG (NREG),
            .WAYS (WAYS)
        ) u_rt_sel (
            .sel   (rt_sel),
            .rd    (rf.i_rd),
            .we    (rf.i_rd_we),
            .wdata (rf.i_wdata),
            .hit   (rt_hit),
            .data  (rt_byp)
        );

        // Bypass ignores gwe; a same-cycle alloc keeps the stored busy bit visible.
        assign rs_data[w] = rs_hit ? rs_byp : regs_q[rs_sel];
        assign rt_data[w] = rt_hit ? rt_byp : regs_q[rt_sel];
        assign rs_busy[w] = busy_q[rs_sel] & ~(rs_hit & ~alloc_vec[rs_sel]);
        assign rt_busy[w] = busy_q[rt_sel] & ~(rt_hit & ~alloc_vec[rt_sel]);
`else
        assign rs_data[w] = regs_q[rs_sel];
        assign rt_data[w] = regs_q[rt_sel];
        assign rs_busy[w] = busy_q[rs_sel];
        assign rt_busy[w] = busy_q[rt_sel];
`endif
    end

    always_comb begin
        rf.o_rs_data = '0;
        rf.o_rt_data = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            rf.o_rs_data[w*n +: n] = rs_data[w];
            rf.o_rt_data[w*n +: n] = rt_data[w];
        end
        rf.o_rs_busy = rs_busy;
        rf.o_rt_busy = rt_busy;
    end

endmodule

// File: tb/tb_lc4_regfile_sb.sv
// Bench for lc4_regfile_sb: directed vector table then random traffic against a reference model.
// Expectations follow LC4_REGFILE_BYPASS_EN when it is defined.
module tb_lc4_regfile_sb;
    import lc4_regfile_sb_pkg::*;

    localparam int unsigned N  = 16;
    localparam int unsigned NR = 8;
    localparam int unsigned W  = 2;
    localparam int unsigned AW = 3;
`ifdef LC4_REGFILE_BYPASS_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lc4_regfile_sb_if #(.n(N), .NREG(NR), .WAYS(W)) rf ();

    lc4_regfile_sb #(.n(N), .NREG(NR), .WAYS(W)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf)
    );

    typedef struct {
        string       name;
        bit          rst;
        bit          gwe;
        bit          we0;
        int          rd0;
        logic [15:0] wd0;
        bit          we1;
        int          rd1;
        logic [15:0] wd1;
        bit          a0;
        int          ar0;
        bit          a1;
        int          ar1;
        int          src;
        logic [15:0] ed;
        bit          eb;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state and current stimulus
    logic [15:0] m_reg  [NR];
    bit          m_busy [NR];
    bit          s_gwe;
    bit          s_we  [W];
    int          s_rd  [W];
    logic [15:0] s_wd  [W];
    bit          s_awe [W];
    int          s_ar  [W];
    int          s_rs  [W];
    int          s_rt  [W];

    vec_t vecs[$];

    function automatic vec_t mkv(string name, bit r, bit g,
                                 bit we0, int rd0, logic [15:0] wd0,
                                 bit we1, int rd1, logic [15:0] wd1,
                                 bit a0, int ar0, bit a1, int ar1,
                                 int src, logic [15:0] ed, bit eb);
        vec_t v;
        v.name = name; v.rst = r; v.gwe = g;
        v.we0 = we0; v.rd0 = rd0; v.wd0 = wd0;
        v.we1 = we1; v.rd1 = rd1; v.wd1 = wd1;
        v.a0 = a0; v.ar0 = ar0; v.a1 = a1; v.ar1 = ar1;
        v.src = src; v.ed = ed; v.eb = eb;
        return v;
    endfunction

    task automatic apply();
        rf.gwe = s_gwe;
        for (int w = 0; w < int'(W); w++) begin
            rf.i_rd_we[w]            = s_we[w];
            rf.i_rd[w*AW +: AW]      = AW'(s_rd[w]);
            rf.i_wdata[w*N +: N]     = s_wd[w];
            rf.i_alloc_we[w]         = s_awe[w];
            rf.i_alloc_rd[w*AW +: AW] = AW'(s_ar[w]);
            rf.i_rs[w*AW +: AW]      = AW'(s_rs[w]);
            rf.i_rt[w*AW +: AW]      = AW'(s_rt[w]);
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Value a read of register s should see this cycle.
    function automatic logic [15:0] exp_data(int s);
        logic [15:0] d = m_reg[s];
        if (BP) begin
            for (int w = 0; w < int'(W); w++)
                if (s_we[w] && s_rd[w] == s) d = s_wd[w];
        end
        return d;
    endfunction

    function automatic bit exp_busy(int s);
        bit any_wb = 1'b0;
        bit any_al = 1'b0;
        for (int w = 0; w < int'(W); w++) begin
            if (s_we[w] && s_rd[w] == s) any_wb = 1'b1;
            if (s_awe[w] && s_ar[w] == s) any_al = 1'b1;
        end
        return (BP && any_wb && !any_al) ? 1'b0 : m_busy[s];
    endfunction

    function automatic void model_update();
        bit any_wb [NR];
        bit any_al [NR];
        if (rst) begin
            for (int r = 0; r < int'(NR); r++) begin
                m_reg[r]  = '0;
                m_busy[r] = 1'b0;
            end
        end else if (s_gwe) begin
            for (int r = 0; r < int'(NR); r++) begin
                any_wb[r] = 1'b0;
                any_al[r] = 1'b0;
            end
            for (int w = 0; w < int'(W); w++) begin
                if (s_we[w]) begin
                    m_reg[s_rd[w]]  = s_wd[w];
                    any_wb[s_rd[w]] = 1'b1;
                end
                if (s_awe[w]) any_al[s_ar[w]] = 1'b1;
            end
            for (int r = 0; r < int'(NR); r++) begin
                if (any_al[r]) m_busy[r] = 1'b1;
                else if (any_wb[r]) m_busy[r] = 1'b0;
            end
        end
    endfunction

    task automatic clear_stim();
        s_gwe = 1'b1;
        for (int w = 0; w < int'(W); w++) begin
            s_we[w] = 1'b0; s_rd[w] = 0; s_wd[w] = '0;
            s_awe[w] = 1'b0; s_ar[w] = 0; s_rs[w] = 0; s_rt[w] = 0;
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        for (int r = 0; r < int'(NR); r++)
            vecs.push_back(mkv("rst_read", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r, 16'h0, 0));
        vecs.push_back(mkv("dual_wr_r3", 0, 1, 1, 3, 16'h1111, 1, 3, 16'h2222, 0, 0, 0, 0,
                           3, BP ? 16'h2222 : 16'h0000, 0));
        vecs.push_back(mkv("r3_next", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 16'h2222, 0));
        vecs.push_back(mkv("gwe0_r5", 0, 0, 1, 5, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0,
                           5, BP ? 16'hBEEF : 16'h0000, 0));
        vecs.push_back(mkv("r5_held", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 16'h0000, 0));
        vecs.push_back(mkv("alloc_r2", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 16'h0000, 0));
        vecs.push_back(mkv("r2_busy", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 16'h0000, 1));
        vecs.push_back(mkv("wb_r2", 0, 1, 1, 2, 16'h1234, 0, 0, 0, 0, 0, 0, 0,
                           2, BP ? 16'h1234 : 16'h0000, !BP));
        vecs.push_back(mkv("r2_clear", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 16'h1234, 0));
        vecs.push_back(mkv("alloc_wb_r4", 0, 1, 0, 0, 0, 1, 4, 16'h4444, 1, 4, 0, 0,
                           4, BP ? 16'h4444 : 16'h0000, 0));
        vecs.push_back(mkv("r4_busy", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 16'h4444, 1));
        vecs.push_back(mkv("rst_r7", 1, 1, 1, 7, 16'hFFFF, 0, 0, 0, 0, 0, 1, 7,
                           7, BP ? 16'hFFFF : 16'h0000, 0));
        vecs.push_back(mkv("r7_after_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 16'h0, 0));
        vecs.push_back(mkv("r4_after_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 16'h0, 0));

        // Initial reset, outputs unchecked since storage starts unknown
        rst = 1'b1;
        clear_stim();
        apply();
        next_edge();

        foreach (vecs[i]) begin
            vec_t v = vecs[i];
            clear_stim();
            rst      = v.rst;
            s_gwe    = v.gwe;
            s_we[0]  = v.we0; s_rd[0] = v.rd0; s_wd[0] = v.wd0;
            s_we[1]  = v.we1; s_rd[1] = v.rd1; s_wd[1] = v.wd1;
            s_awe[0] = v.a0;  s_ar[0] = v.ar0;
            s_awe[1] = v.a1;  s_ar[1] = v.ar1;
            for (int w = 0; w < int'(W); w++) begin
                s_rs[w] = v.src;
                s_rt[w] = v.src;
            end
            apply();
            #2;
            for (int w = 0; w < int'(W); w++) begin
                check($sformatf("%s rs_data w%0d", v.name, w),
                      32'(rf.o_rs_data[w*N +: N]), 32'(v.ed));
                check($sformatf("%s rt_data w%0d", v.name, w),
                      32'(rf.o_rt_data[w*N +: N]), 32'(v.ed));
                check($sformatf("%s rs_busy w%0d", v.name, w), 32'(rf.o_rs_busy[w]), 32'(v.eb));
                check($sformatf("%s rt_busy w%0d", v.name, w), 32'(rf.o_rt_busy[w]), 32'(v.eb));
            end
            next_edge();
        end

        for (int c = 0; c < 500; c++) begin
            rst   = ($urandom_range(0, 39) == 0);
            s_gwe = ($urandom_range(0, 3) != 0);
            for (int w = 0; w < int'(W); w++) begin
                s_we[w]  = $urandom_range(0, 1);
                s_rd[w]  = $urandom_range(0, NR - 1);
                s_wd[w]  = 16'($urandom);
                s_awe[w] = ($urandom_range(0, 2) == 0);
                s_ar[w]  = $urandom_range(0, NR - 1);
                s_rs[w]  = $urandom_range(0, NR - 1);
                s_rt[w]  = $urandom_range(0, NR - 1);
            end
            apply();
            #2;
            for (int w = 0; w < int'(W); w++) begin
                check($sformatf("rnd%0d rs_data w%0d", c, w),
                      32'(rf.o_rs_data[w*N +: N]), 32'(exp_data(s_rs[w])));
                check($sformatf("rnd%0d rt_data w%0d", c, w),
                      32'(rf.o_rt_data[w*N +: N]), 32'(exp_data(s_rt[w])));
                check($sformatf("rnd%0d rs_busy w%0d", c, w),
                      32'(rf.o_rs_busy[w]), 32'(exp_busy(s_rs[w])));
                check($sformatf("rnd%0d rt_busy w%0d", c, w),
                      32'(rf.o_rt_busy[w]), 32'(exp_busy(s_rt[w])));
            end
            next_edge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
